// File: rtl/vga_scan_driver_if.sv
// Scan-side bundle between the raster generator and the colour mapper / DAC.
// The master is the scan driver; the slave supplies colour and consumes timing.
interface vga_scan_driver_if;
  logic [7:0] Red_in;
  logic [7:0] Green_in;
  logic [7:0] Blue_in;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       pixel_clk_en;
  logic       frame_start;
  logic       hs;
  logic       vs;
  logic       blank;
  logic [7:0] VGA_R;
  logic [7:0] VGA_G;
  logic [7:0] VGA_B;

  modport master (
    input  Red_in, Green_in, Blue_in,
    output DrawX, DrawY, pixel_clk_en, frame_start, hs, vs, blank,
           VGA_R, VGA_G, VGA_B
  );

  modport slave (
    output Red_in, Green_in, Blue_in,
    input  DrawX, DrawY, pixel_clk_en, frame_start, hs, vs, blank,
           VGA_R, VGA_G, VGA_B
  );
endinterface

// File: rtl/vga_scan_driver.sv
// Raster timing generator: pixel divider, h/v scan counters, and a registered
// output stage that keeps sync, blank and colour one pixel behind DrawX/DrawY.
module vga_scan_driver #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic               Clk,
  input  logic               Reset,
  vga_scan_driver_if.master  vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [2:0]  DIV_LAST = 3'(CLK_DIV - 1);
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  // 11-bit bounds so a sync window ending exactly at 1024 cannot alias to 0.
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

  logic [2:0] div_q, div_d;
  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic       frame_start_q, frame_start_d;
  logic       blank_q, blank_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic [7:0] r_q, r_d;
  logic [7:0] g_q, g_d;
  logic [7:0] b_q, b_d;

  logic        tick;
  logic        h_wrap;
  logic        v_wrap;
  logic        display_en;
  logic [10:0] hc_ext;
  logic [10:0] vc_ext;

  assign tick   = (div_q == DIV_LAST);
  assign hc_ext = {1'b0, hc_q};
  assign vc_ext = {1'b0, vc_q};
  // ">=" rather than "==" so a forced out-of-range count recovers on the next tick.
  assign h_wrap = (hc_q >= H_LAST);
  assign v_wrap = (vc_q >= V_LAST);
  assign display_en = (hc_ext < H_VIS) && (vc_ext < V_VIS);

  // NOTE: every signal assigned here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    div_d         = (div_q >= DIV_LAST) ? 3'd0 : div_q + 3'd1;
    hc_d          = hc_q;
    vc_d          = vc_q;
    frame_start_d = 1'b0;
    blank_d       = blank_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    r_d           = r_q;
    g_d           = g_q;
    b_d           = b_q;

    if (tick) begin
      hc_d = h_wrap ? 10'd0 : hc_q + 10'd1;
      if (h_wrap) begin
        vc_d = v_wrap ? 10'd0 : vc_q + 10'd1;
      end
      frame_start_d = h_wrap && v_wrap;
      // Decoded from the pre-tick count: outputs trail DrawX/DrawY by one pixel.
      blank_d = display_en;
      hs_d    = !((hc_ext >= HS_START) && (hc_ext < HS_END));
      vs_d    = !((vc_ext >= VS_START) && (vc_ext < VS_END));
      r_d     = display_en ? vga.Red_in   : 8'd0;
      g_d     = display_en ? vga.Green_in : 8'd0;
      b_d     = display_en ? vga.Blue_in  : 8'd0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      div_q         <= 3'd0;
      hc_q          <= 10'd0;
      vc_q          <= 10'd0;
      frame_start_q <= 1'b0;
      blank_q       <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      r_q           <= 8'd0;
      g_q           <= 8'd0;
      b_q           <= 8'd0;
    end else begin
      div_q         <= div_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      frame_start_q <= frame_start_d;
      blank_q       <= blank_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
    end
  end

  assign vga.DrawX        = hc_q;
  assign vga.DrawY        = vc_q;
  assign vga.pixel_clk_en = tick;
  assign vga.frame_start  = frame_start_q;
  assign vga.blank        = blank_q;
  assign vga.hs           = hs_q;
  assign vga.vs           = vs_q;
  assign vga.VGA_R        = r_q;
  assign vga.VGA_G        = g_q;
  assign vga.VGA_B        = b_q;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Directed bench: default 640x480 timing (a) and a tiny CLK_DIV=1 raster (b)
// share one clock and reset; expected values are hand-derived edge by edge.
module tb_vga_scan_driver;

  logic Clk;
  logic Reset;
  int   checks;
  int   errors;
  int   edge_no;

  vga_scan_driver_if if_a ();
  vga_scan_driver_if if_b ();

  vga_scan_driver dut_a (
    .Clk   (Clk),
    .Reset (Reset),
    .vga   (if_a)
  );

  // 14-tick lines, 7-line frames, one tick per Clk.
  vga_scan_driver #(
    .CLK_DIV   (1),
    .H_VISIBLE (8),
    .H_FP      (2),
    .H_SYNC    (2),
    .H_BP      (2),
    .V_VISIBLE (4),
    .V_FP      (1),
    .V_SYNC    (1),
    .V_BP      (1)
  ) dut_b (
    .Clk   (Clk),
    .Reset (Reset),
    .vga   (if_b)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the given rising edge (counted from reset release), sample 1ns later.
  task automatic goto(input int target);
    while (edge_no < target) begin
      @(posedge Clk);
      edge_no++;
    end
    #1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    edge_no = 0;
    Reset   = 1'b0;
    if_a.Red_in   = 8'hCA;
    if_a.Green_in = 8'h35;
    if_a.Blue_in  = 8'h5C;
    if_b.Red_in   = 8'hA5;
    if_b.Green_in = 8'h3C;
    if_b.Blue_in  = 8'h0F;

    repeat (3) @(posedge Clk);
    #1;
    check("rst_a_drawx", if_a.DrawX, 0);
    check("rst_a_drawy", if_a.DrawY, 0);
    check("rst_a_pce",   if_a.pixel_clk_en, 0);
    check("rst_a_fs",    if_a.frame_start, 0);
    check("rst_a_blank", if_a.blank, 0);
    check("rst_a_r",     if_a.VGA_R, 0);
    check("rst_a_hs",    if_a.hs, 1);
    check("rst_a_vs",    if_a.vs, 1);
    check("rst_b_pce",   if_b.pixel_clk_en, 1);

    Reset   = 1'b1;
    edge_no = 0;
    goto(1);
    check("rel1_a_pce",   if_a.pixel_clk_en, 1);
    check("rel1_a_drawx", if_a.DrawX, 0);
    check("rel1_b_drawx", if_b.DrawX, 1);
    goto(2);
    check("rel2_a_drawx", if_a.DrawX, 1);
    check("rel2_a_pce",   if_a.pixel_clk_en, 0);
    goto(600);
    check("mid_a_drawx", if_a.DrawX, 300);
    check("mid_a_drawy", if_a.DrawY, 0);
    check("mid_b_drawx", if_b.DrawX, 12);
    check("mid_b_hs",    if_b.hs, 0);

    // Reset in the middle of dut_b's sync pulse must end it at once.
    Reset = 1'b0;
    #1;
    check("arst_a_drawx", if_a.DrawX, 0);
    check("arst_a_pce",   if_a.pixel_clk_en, 0);
    check("arst_a_blank", if_a.blank, 0);
    check("arst_a_r",     if_a.VGA_R, 0);
    check("arst_a_hs",    if_a.hs, 1);
    check("arst_b_hs",    if_b.hs, 1);
    check("arst_b_drawx", if_b.DrawX, 0);
    repeat (2) @(posedge Clk);
    #1;
    check("hold_a_drawx", if_a.DrawX, 0);

    Reset   = 1'b1;
    edge_no = 0;
    goto(1);
    check("r1_a_pce",   if_a.pixel_clk_en, 1);
    check("r1_a_drawx", if_a.DrawX, 0);
    check("r1_b_drawx", if_b.DrawX, 1);
    check("r1_b_drawy", if_b.DrawY, 0);
    check("r1_b_blank", if_b.blank, 1);
    check("r1_b_r",     if_b.VGA_R, 8'hA5);
    check("r1_b_fs",    if_b.frame_start, 0);
    check("r1_b_pce",   if_b.pixel_clk_en, 1);
    goto(2);
    check("r2_a_drawx", if_a.DrawX, 1);
    check("r2_a_pce",   if_a.pixel_clk_en, 0);
    check("r2_a_blank", if_a.blank, 1);
    check("r2_a_r",     if_a.VGA_R, 8'hCA);
    check("r2_a_b",     if_a.VGA_B, 8'h5C);
    check("r2_a_hs",    if_a.hs, 1);
    check("r2_a_fs",    if_a.frame_start, 0);

    goto(8);
    check("b_vis_end_blank", if_b.blank, 1);
    check("b_vis_end_b",     if_b.VGA_B, 8'h0F);
    goto(9);
    check("b_hblank_blank", if_b.blank, 0);
    check("b_hblank_r",     if_b.VGA_R, 0);
    goto(10);
    check("b_hs_pre",   if_b.hs, 1);
    goto(11);
    check("b_hs_low0",  if_b.hs, 0);
    goto(12);
    check("b_hs_low1",  if_b.hs, 0);
    goto(13);
    check("b_hs_post",  if_b.hs, 1);
    goto(14);
    check("b_hwrap_drawx", if_b.DrawX, 0);
    check("b_hwrap_drawy", if_b.DrawY, 1);
    check("b_hwrap_fs",    if_b.frame_start, 0);
    goto(43);
    check("b_lastvis_blank", if_b.blank, 1);
    goto(57);
    check("b_vblank_drawy", if_b.DrawY, 4);
    check("b_vblank_blank", if_b.blank, 0);
    check("b_vblank_g",     if_b.VGA_G, 0);
    goto(70);
    check("b_vs_pre",  if_b.vs, 1);
    goto(71);
    check("b_vs_low0", if_b.vs, 0);
    goto(84);
    check("b_vs_low1", if_b.vs, 0);
    goto(85);
    check("b_vs_post", if_b.vs, 1);
    goto(97);
    check("b_f_pre_fs",    if_b.frame_start, 0);
    check("b_f_pre_drawx", if_b.DrawX, 13);
    check("b_f_pre_drawy", if_b.DrawY, 6);
    goto(98);
    check("b_f_fs",    if_b.frame_start, 1);
    check("b_f_drawx", if_b.DrawX, 0);
    check("b_f_drawy", if_b.DrawY, 0);
    goto(99);
    check("b_f_post_fs",    if_b.frame_start, 0);
    check("b_f_post_drawx", if_b.DrawX, 1);
    goto(196);
    check("b_f2_fs", if_b.frame_start, 1);
    goto(197);
    check("b_f2_post_fs", if_b.frame_start, 0);

    goto(1280);
    check("a_lastvis_r",     if_a.VGA_R, 8'hCA);
    check("a_lastvis_g",     if_a.VGA_G, 8'h35);
    check("a_lastvis_blank", if_a.blank, 1);
    goto(1282);
    check("a_hblank_r",     if_a.VGA_R, 0);
    check("a_hblank_b",     if_a.VGA_B, 0);
    check("a_hblank_blank", if_a.blank, 0);
    goto(1312);
    check("a_hs_pre",  if_a.hs, 1);
    goto(1314);
    check("a_hs_fall", if_a.hs, 0);
    goto(1504);
    check("a_hs_last", if_a.hs, 0);
    goto(1506);
    check("a_hs_rise", if_a.hs, 1);
    goto(1600);
    check("a_wrap_drawx", if_a.DrawX, 0);
    check("a_wrap_drawy", if_a.DrawY, 1);
    check("a_wrap_r",     if_a.VGA_R, 0);
    check("a_wrap_fs",    if_a.frame_start, 0);
    check("a_wrap_vs",    if_a.vs, 1);
    goto(1602);
    check("a_l1_r",     if_a.VGA_R, 8'hCA);
    check("a_l1_g",     if_a.VGA_G, 8'h35);
    check("a_l1_blank", if_a.blank, 1);

    // Green_in changes between ticks; only the value at tick edges may land.
    if_a.Green_in = 8'h11;
    goto(1603);
    if_a.Green_in = 8'h22;
    goto(1604);
    check("a_samp_tick0", if_a.VGA_G, 8'h22);
    if_a.Green_in = 8'h77;
    goto(1605);
    check("a_samp_hold", if_a.VGA_G, 8'h22);
    if_a.Green_in = 8'h44;
    goto(1606);
    check("a_samp_tick1", if_a.VGA_G, 8'h44);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_scan_driver.md
# vga_scan_driver

Raster timing generator and pixel output stage for the VGA path. It produces the `DrawX`/`DrawY` scan coordinates consumed by `color_mapper`, and registers the returned `Red`/`Green`/`Blue`. During blanking it forces the colour outputs to zero. It also generates sync, blank and a once-per-frame strobe, which drives game-object position updates.

## Interface
- `CLK_DIV`, 2, number of `Clk` cycles per pixel (1..8)
- `H_VISIBLE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch, in pixels
- `H_SYNC`, 96, horizontal sync width, in pixels
- `H_BP`, 48, horizontal back porch, in pixels
- `V_VISIBLE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch, in lines
- `V_SYNC`, 2, vertical sync width, in lines
- `V_BP`, 33, vertical back porch, in lines
- Constraint: both H_TOTAL (sum of the H_ parameters) and V_TOTAL (sum of the V_ parameters) must be ≤ 1024.
- `Clk`  in  1  system clock (50 MHz); one clock domain; reset is asynchronous and active-low
- `Reset`  in  1  asynchronous, active-low reset
- `Red_in`, `Green_in`, `Blue_in`  in  8 each  colour for the current `DrawX`/`DrawY`, from `color_mapper`
- `DrawX`  out  10  current horizontal count (the `hc` register)
- `DrawY`  out  10  current vertical count (the `vc` register)
- `pixel_clk_en`  out  1  pixel tick; high for one `Clk` cycle per pixel
- `frame_start`  out  1  one-`Clk` pulse marking the start of each frame
- `hs`  out  1  horizontal sync, active-low
- `vs`  out  1  vertical sync, active-low
- `blank`  out  1  1 = active video, 0 = blanking
- `VGA_R`, `VGA_G`, `VGA_B`  out  8 each  registered pixel colour

## Operation
- **Divider:** `div` counts 0..CLK_DIV-1 and wraps.
  - `pixel_clk_en` = (`div` == CLK_DIV-1), decoded from the register.
  - With CLK_DIV=1, `pixel_clk_en` is constantly 1 outside reset.
- **Counters:** these advance only on `Clk` edges where `pixel_clk_en` = 1.
  - `hc` increments; at H_TOTAL-1 it wraps to 0.
  - On that wrap, `vc` increments; at V_TOTAL-1 it wraps to 0.
  - Counters are 10-bit unsigned. No other wrap points exist.
- **Output decode:** `display_en` = (`hc` < H_VISIBLE) && (`vc` < V_VISIBLE). All of the following register only on tick edges:
  - `VGA_R`/`G`/`B` ← `display_en` ? `*_in` : 0
  - `blank` ← `display_en`
  - `hs` ← !(`hc` ≥ H_VISIBLE+H_FP && `hc` < H_VISIBLE+H_FP+H_SYNC)
  - `vs` ← !(`vc` ≥ V_VISIBLE+V_FP && `vc` < V_VISIBLE+V_FP+V_SYNC)
- **Alignment:** `hs`, `vs`, `blank` and RGB are therefore exactly one pixel behind `DrawX`/`DrawY`. This compensates for the combinational `color_mapper` and keeps sync aligned with colour.
- **`frame_start`:**
  - Set on the tick edge where `hc` wraps from H_TOTAL-1 and `vc` wraps from V_TOTAL-1.
  - Cleared on the next `Clk` edge.
  - It is therefore high during the first `Clk` cycle in which `DrawX` = 0 and `DrawY` = 0.
  - No pulse is issued for the implicit frame that begins at reset.
- **Input sampling:** `*_in` are sampled only on tick edges. Changes between ticks have no effect.

## Timing
- **Reset values (asynchronous on Reset=0):**
  - `div`, `hc`, `vc` = 0; `pixel_clk_en` = 0 (it is 1 during reset only if CLK_DIV=1)
  - `frame_start` = 0; `blank` = 0; `VGA_*` = 0
  - `hs` = 1, `vs` = 1
- **After reset release:** the first tick occurs at the CLK_DIV-th rising edge.
- **Reset mid-frame:** all state returns to the reset values immediately. No partial sync pulse is completed.
- **Latency:**
  - `DrawX`/`DrawY` change on the tick edge, at zero latency from the counter.
  - RGB, `hs`, `vs` and `blank` reflect counter value N on the tick edge that moves the counter to N+1.
- **Default periods:**
  - Line = 800 ticks = 1600 `Clk`.
  - Frame = 525 lines = 840 000 `Clk`.
  - `hs` low for 96 ticks per line.
  - `vs` low for 2 lines = 1600 ticks.
- **Simultaneous wraps:** when the `hc` wrap and `vc` wrap coincide, `vc`→0, `hc`→0 and `frame_start` rise on the same edge.
- **Unused code space:** `hc` ≥ H_TOTAL or `vc` ≥ V_TOTAL is unreachable. If it is forced, the counter wraps to 0 on the next tick.

## Test plan
1. **Reset:** assert Reset=0 mid-line with `hc`=300 → all outputs take their reset values within the same cycle. Release → first `pixel_clk_en` at the 2nd edge, and `DrawX` becomes 1 on that edge.
2. **Line timing:** `Red_in`=0xCA constant → `VGA_R`=0xCA for ticks where the prior `hc` was 0..639, 0 for 640..799. `hs` falls on the edge that moves `hc` 656→657 and stays low for 96 ticks.
3. **Vertical blanking:** over lines 480..524, `VGA_*`=0 and `blank`=0 regardless of inputs. `vs` is low exactly while the prior `vc` ∈ {490, 491}, i.e. 3200 `Clk`.
4. **Frame strobe:** `frame_start` pulses are exactly 840 000 `Clk` apart, each 1 cycle wide, coincident with `DrawX`=`DrawY`=0. No pulse follows reset release.
5. **Sampling window:** toggle `Green_in` between ticks → `VGA_G` reflects only the values present at tick edges.
6. **Parameter variant:** CLK_DIV=1, H_VISIBLE=8, H_FP=2, H_SYNC=2, H_BP=2, V_VISIBLE=4, V_FP=1, V_SYNC=1, V_BP=1 → 14-cycle lines, 98-cycle frames, and `hs` low for 2 cycles per line.
